// File: rtl/mem_sys_if.sv
// rtl/mem_sys_if.sv - access/fault/status bundle between a memory client and mem_sys
//   enable, we, wra, wrd, rda             : access controls (client -> memory)
//   fault_en, fault_addr, fault_s1/_s0    : stuck-bit injection on reads (client -> memory)
//   rdd, ready, wr_count, rd_count        : read data and status (memory -> client)
interface mem_sys_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          enable;
    logic          we;
    logic [AW-1:0] wra;
    logic [DW-1:0] wrd;
    logic [AW-1:0] rda;
    logic [DW-1:0] rdd;
    logic          ready;
    logic          fault_en;
    logic [AW-1:0] fault_addr;
    logic [DW-1:0] fault_s1;
    logic [DW-1:0] fault_s0;
    logic [8:0]    wr_count;
    logic [8:0]    rd_count;

    modport master (
        output enable, we, wra, wrd, rda, fault_en, fault_addr, fault_s1, fault_s0,
        input  rdd, ready, wr_count, rd_count
    );

    modport slave (
        input  enable, we, wra, wrd, rda, fault_en, fault_addr, fault_s1, fault_s0,
        output rdd, ready, wr_count, rd_count
    );
endinterface

// File: rtl/mem_sys.sv
// rtl/mem_sys.sv - zero-fill-on-reset RAM with a 1-cycle pipelined read and stuck-bit fault injection
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_sys_if slave (enable, we/wra/wrd write port, rda/rdd read port,
//           fault_en/fault_addr/fault_s1/fault_s0, ready, wr_count, rd_count)
module mem_sys #(
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic      clock,
    input  logic      reset,
    mem_sys_if.slave  bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] ra_q;
    logic          v1;
    logic [DW-1:0] rdd_q;
    logic [8:0]    wr_count_q;
    logic [8:0]    rd_count_q;

    logic [DW-1:0] mem [DEPTH];

    logic          in_ready;
    logic          do_write;
    logic          do_read;
    logic [DW-1:0] rd_raw;
    logic [DW-1:0] rd_fault;

    assign in_ready = (state == READY);
    assign do_write = bus.enable && in_ready && bus.we;
    assign do_read  = bus.enable && in_ready && v1;

    // Write-first: a write landing on the address being read this edge wins.
    always_comb begin
        rd_raw = mem[ra_q];
        if (do_write && (bus.wra == ra_q)) begin
            rd_raw = bus.wrd;
        end
    end

    // Fault is applied on the read path only; s0 is applied last so it wins.
    always_comb begin
        rd_fault = rd_raw;
        if (bus.fault_en && (ra_q == bus.fault_addr)) begin
            rd_fault = (rd_raw | bus.fault_s1) & ~bus.fault_s0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.enable && (state == CLEAR) && (clr_ptr == AW'(DEPTH - 1))) begin
            state_next = READY;
        end
    end

    // Array has no reset; zeroing happens only through the CLEAR sweep.
    always_ff @(posedge clock) begin
        if (bus.enable) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (bus.we) begin
                mem[bus.wra] <= bus.wrd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_ptr    <= '0;
            ra_q       <= '0;
            v1         <= 1'b0;
            rdd_q      <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else if (bus.enable) begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end else begin
                ra_q <= bus.rda;
                v1   <= 1'b1;
            end
            if (do_read) begin
                rdd_q <= rd_fault;
                if (rd_count_q != 9'd511) begin
                    rd_count_q <= rd_count_q + 9'd1;
                end
            end
            if (do_write && (wr_count_q != 9'd511)) begin
                wr_count_q <= wr_count_q + 9'd1;
            end
        end
    end

    assign bus.rdd      = rdd_q;
    assign bus.ready    = in_ready;
    assign bus.wr_count = wr_count_q;
    assign bus.rd_count = rd_count_q;
endmodule

// File: tb/tb_mem_sys.sv
// tb/tb_mem_sys.sv - directed self-checking bench for mem_sys
module tb_mem_sys;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   bad;

    mem_sys_if #(.AW(8), .DW(8)) bus ();

    mem_sys #(.AW(8), .DW(8), .CLEAR_ON_RESET(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rw(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                          input logic [7:0] ra);
        bus.we  = w;
        bus.wra = wa;
        bus.wrd = wd;
        bus.rda = ra;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        bus.enable     = 1'b0;
        bus.fault_en   = 1'b0;
        bus.fault_addr = 8'h00;
        bus.fault_s1   = 8'h00;
        bus.fault_s0   = 8'h00;
        set_rw(1'b0, 8'h00, 8'h00, 8'h00);

        repeat (3) tick();
        check("rst_rdd", 32'(bus.rdd), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_wr_count", 32'(bus.wr_count), 32'h0);
        check("rst_rd_count", 32'(bus.rd_count), 32'h0);

        // Clear sweep: we/rda are ignored while clearing.
        @(negedge clock);
        reset      = 1'b1;
        bus.enable = 1'b1;
        set_rw(1'b1, 8'h44, 8'hEE, 8'h44);
        tick();
        check("clr_ready_edge1", 32'(bus.ready), 32'h0);
        repeat (254) tick();
        check("clr_ready_edge255", 32'(bus.ready), 32'h0);
        check("clr_rdd_zero", 32'(bus.rdd), 32'h0);
        check("clr_wr_hold", 32'(bus.wr_count), 32'h0);
        tick();
        check("clr_ready_edge256", 32'(bus.ready), 32'h1);

        // Read every address: 257 READY edges, the first only primes v1.
        bad = 0;
        for (int i = 0; i <= 256; i++) begin
            set_rw(1'b0, 8'h00, 8'h00, 8'(i));
            tick();
            if (i >= 1 && bus.rdd !== 8'h00) bad++;
        end
        check("clear_readback_bad", 32'(bad), 32'h0);
        check("readall_rd_count", 32'(bus.rd_count), 32'd256);
        check("readall_wr_count", 32'(bus.wr_count), 32'd0);

        // Basic write then pipelined read.
        set_rw(1'b1, 8'h10, 8'hA5, 8'h00);
        tick();
        set_rw(1'b0, 8'h00, 8'h00, 8'h10);
        tick();
        set_rw(1'b0, 8'h00, 8'h00, 8'h11);
        tick();
        check("wr_rd_0x10", 32'(bus.rdd), 32'hA5);
        check("wr_count_1", 32'(bus.wr_count), 32'd1);
        check("rd_count_259", 32'(bus.rd_count), 32'd259);

        // Same-edge write and stage-2 read at 0x20.
        set_rw(1'b0, 8'h00, 8'h00, 8'h20);
        tick();
        set_rw(1'b1, 8'h20, 8'h3C, 8'h21);
        tick();
        check("write_first_0x20", 32'(bus.rdd), 32'h3C);

        // Fault injection.
        set_rw(1'b1, 8'h05, 8'hFF, 8'h00);
        tick();
        set_rw(1'b1, 8'h06, 8'h81, 8'h00);
        tick();
        set_rw(1'b0, 8'h00, 8'h00, 8'h05);
        bus.fault_en   = 1'b1;
        bus.fault_addr = 8'h05;
        bus.fault_s1   = 8'h01;
        bus.fault_s0   = 8'h80;
        tick();
        set_rw(1'b0, 8'h00, 8'h00, 8'h06);
        tick();
        check("fault_0x05", 32'(bus.rdd), 32'h7F);
        set_rw(1'b0, 8'h00, 8'h00, 8'h05);
        tick();
        check("nofault_0x06", 32'(bus.rdd), 32'h81);
        bus.fault_en = 1'b0;
        set_rw(1'b0, 8'h00, 8'h00, 8'h07);
        tick();
        check("fault_off_0x05", 32'(bus.rdd), 32'hFF);

        // Fault with s1/s0 overlapping: s0 wins.
        bus.fault_en   = 1'b1;
        bus.fault_addr = 8'h10;
        bus.fault_s1   = 8'h0F;
        bus.fault_s0   = 8'h05;
        set_rw(1'b0, 8'h00, 8'h00, 8'h10);
        tick();
        tick();
        check("fault_s0_wins", 32'(bus.rdd), 32'hAA);
        bus.fault_en = 1'b0;

        // Tester sequence: write then read each address, 0x00 pass then 0xFF pass.
        for (int p = 0; p < 2; p++) begin
            bad = 0;
            for (int a = 0; a < 256; a++) begin
                set_rw(1'b1, 8'(a), (p == 0) ? 8'h00 : 8'hFF, 8'(a));
                tick();
                set_rw(1'b0, 8'h00, 8'h00, 8'(a));
                tick();
                if (bus.rdd !== ((p == 0) ? 8'h00 : 8'hFF)) bad++;
            end
            check((p == 0) ? "tester_00_bad" : "tester_ff_bad", 32'(bad), 32'h0);
        end
        check("wr_count_sat", 32'(bus.wr_count), 32'd511);
        check("rd_count_sat", 32'(bus.rd_count), 32'd511);

        // Freeze: enable=0 with live inputs for 10 cycles.
        bus.enable = 1'b0;
        set_rw(1'b1, 8'h30, 8'h55, 8'h31);
        repeat (10) tick();
        check("frz_rdd", 32'(bus.rdd), 32'hFF);
        check("frz_ready", 32'(bus.ready), 32'h1);
        check("frz_wr_count", 32'(bus.wr_count), 32'd511);
        check("frz_rd_count", 32'(bus.rd_count), 32'd511);
        bus.enable = 1'b1;
        set_rw(1'b0, 8'h00, 8'h00, 8'h30);
        tick();
        tick();
        check("frz_no_write_0x30", 32'(bus.rdd), 32'hFF);

        // Reset with a read in flight.
        set_rw(1'b0, 8'h00, 8'h00, 8'h05);
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_rdd", 32'(bus.rdd), 32'h0);
        check("arst_ready", 32'(bus.ready), 32'h0);
        check("arst_rd_count", 32'(bus.rd_count), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (100) tick();
        check("midclr_ready", 32'(bus.ready), 32'h0);

        // Reset mid-CLEAR; the restarted sweep needs a full 256 enabled edges,
        // with a 10-cycle disabled gap that must not advance it.
        #2 reset = 1'b0;
        #1;
        check("midclr_arst_ready", 32'(bus.ready), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (100) tick();
        bus.enable = 1'b0;
        repeat (10) tick();
        check("clr_frz_ready", 32'(bus.ready), 32'h0);
        bus.enable = 1'b1;
        repeat (155) tick();
        check("reclr_ready_edge255", 32'(bus.ready), 32'h0);
        tick();
        check("reclr_ready_edge256", 32'(bus.ready), 32'h1);
        set_rw(1'b0, 8'h00, 8'h00, 8'h30);
        tick();
        set_rw(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        check("reclr_0x30_zero", 32'(bus.rdd), 32'h0);
        check("reclr_rd_count", 32'(bus.rd_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_sys.md
MEM_SYS -- requirements
Module: mem_sys

Interface
REQ-001 Parameter: AW, 8, address width; array depth is 2^AW.
REQ-002 Parameter: DW, 8, data width.
REQ-003 Parameter: CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = ready immediately with contents undefined.
REQ-004 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  1 = accept writes and advance the read pipeline; 0 = freeze all state.
REQ-007 we  in  1  write enable.
REQ-008 wra  in  AW  write address.
REQ-009 wrd  in  DW  write data.
REQ-010 rda  in  AW  read address.
REQ-011 rdd  out  DW  registered read data.
REQ-012 ready  out  1  1 = clear sequence complete and accesses honoured.
REQ-013 fault_en  in  1  enable stuck-bit injection on reads.
REQ-014 fault_addr  in  AW  address that receives the injected fault.
REQ-015 fault_s1  in  DW  bits forced to 1 on faulted reads.
REQ-016 fault_s0  in  DW  bits forced to 0 on faulted reads; s0 wins over s1.
REQ-017 wr_count  out  9  committed writes, saturating at 511.
REQ-018 rd_count  out  9  completed reads, saturating at 511.

Function
REQ-019 The state machine SHALL have two states: CLEAR and READY.
REQ-020 CLEAR: one zero-write per enabled cycle to clr_ptr, clr_ptr incrementing 0..2^AW-1, then READY; ready SHALL rise on the edge that writes the last address.
REQ-021 If CLEAR_ON_RESET=0, reset SHALL leave the machine in READY.
REQ-022 In CLEAR: we, rda and fault inputs SHALL be ignored, rdd SHALL hold 0, and both counters SHALL hold.
REQ-023 Write, in READY with enable=1 and we=1: mem[wra] <= wrd at that edge; wr_count increments.
REQ-024 Read stage 1, in READY with enable=1: rda is registered into ra_q and a valid bit v1 is set.
REQ-025 Read stage 2, next enabled edge with v1=1: rdd <= f(mem[ra_q]); rd_count increments.
REQ-026 Read latency: data for rda sampled at edge k SHALL appear on rdd after edge k+1.
REQ-027 A new read SHALL be accepted every cycle, fully pipelined.
REQ-028 Read-during-write, write-first: if a stage-2 read and a write hit the same address on the same edge, rdd SHALL carry the new wrd, with the fault applied.
REQ-029 A write committed on edge k-1 or earlier SHALL always be visible to the stage-2 read at edge k.
REQ-030 Fault function: f(d) = (d | fault_s1) & ~fault_s0 when fault_en=1 and ra_q==fault_addr, else d.
REQ-031 The fault inputs SHALL be sampled at the stage-2 edge.
REQ-032 Faults SHALL never modify the stored array contents.
REQ-033 With enable=0, no state SHALL change: array, clr_ptr, pipeline, rdd, counters and state all hold.
REQ-034 Both counters SHALL stick at 511 and never wrap.
REQ-035 Address arithmetic SHALL be modulo 2^AW.
REQ-036 rdd SHALL hold its last value between reads.

Reset
REQ-037 On reset=0 asynchronously: rdd=0, ready=0, v1=0, ra_q=0, clr_ptr=0, wr_count=0, rd_count=0, state=CLEAR (READY if CLEAR_ON_RESET=0).
REQ-038 The array SHALL NOT be asynchronously reset; zeroing is done only by the CLEAR sequence.
REQ-039 Reset asserted mid-operation SHALL drop in-flight reads and restart CLEAR from address 0 after release.

Verification
REQ-040 Release reset, enable=1 -> ready=0 for 255 edges and 1 after edge 256; reading every address returns 0x00.
REQ-041 Write 0xA5 to 0x10, then rda=0x10 on the next edge -> rdd=0xA5 after 2 edges; wr_count=1, rd_count=1.
REQ-042 Same-edge write 0x3C and stage-2 read at 0x20 (old value 0x00) -> rdd=0x3C.
REQ-043 fault_en=1, fault_addr=0x05, fault_s1=0x01, fault_s0=0x80, stored 0xFF -> rdd=0x7F; a read of 0x06 is unaffected; after fault_en=0, re-reading 0x05 returns 0xFF.
REQ-044 Drive the tester sequence (write 0x00 then read, for all 256 addresses; then the same with 0xFF) -> no mismatches; counters saturate at 511.
REQ-045 Pull reset low while a read is in flight and mid-CLEAR -> rdd=0 and ready=0 immediately, CLEAR restarts at address 0; enable=0 for 10 cycles -> all outputs unchanged.
